// File: rtl/stop_watch_pkg.sv
// Shared state encodings for the stopwatch control unit.
package stop_watch_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_STOP  = 2'b00,
      ST_RUN   = 2'b01,
      ST_CLEAR = 2'b10
   } state_e;

endpackage

// File: rtl/stop_watch_cu_btn_edge_det.sv
// Rising-edge detector for a debounced button level; one-cycle press event.
// prev resets to 1 so a button held through reset produces no event.
module btn_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_level,
   output logic o_event
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = i_level;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign o_event = i_level & ~prev_q;

endmodule

// File: rtl/stop_watch_cu.sv
// Stopwatch control unit: STOP/RUN/CLEAR sequencer driving the datapath run/clear controls.
// Optional lap-hold output is enabled by defining STOPWATCH_LAP_EN.
module stop_watch_cu
   import stop_watch_pkg::*;
#(
   parameter int unsigned CLEAR_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_btn_run,
   input  logic               i_btn_clear,
   input  logic               i_btn_lap,
   output logic               o_run,
   output logic               o_clear,
   output logic               o_lap_hold,
   output logic [STATE_W-1:0] o_state
);

   localparam int unsigned     CNT_W    = $clog2(CLEAR_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLEAR_CYCLES - 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               run_ev;
   logic               clear_ev;

   btn_edge_det u_run_edge (
      .clk     (clk),
      .rst     (rst),
      .i_level (i_btn_run),
      .o_event (run_ev)
   );

   btn_edge_det u_clear_edge (
      .clk     (clk),
      .rst     (rst),
      .i_level (i_btn_clear),
      .o_event (clear_ev)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_STOP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Events arriving in CLEAR, or a clear event in RUN, are dropped rather than queued.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_STOP: begin
            if (run_ev) begin
               state_d = ST_RUN;
            end else if (clear_ev) begin
               state_d = ST_CLEAR;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_RUN: begin
            if (run_ev) begin
               state_d = ST_STOP;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == '0) begin
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase
   end

`ifdef STOPWATCH_LAP_EN
   logic lap_ev;
   logic lap_hold_q, lap_hold_d;

   btn_edge_det u_lap_edge (
      .clk     (clk),
      .rst     (rst),
      .i_level (i_btn_lap),
      .o_event (lap_ev)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         lap_hold_q <= 1'b0;
      end else begin
         lap_hold_q <= lap_hold_d;
      end
   end

   always_comb begin
      lap_hold_d = lap_hold_q;
      if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) begin
         lap_hold_d = 1'b0;
      end else if (lap_ev) begin
         if (state_q == ST_RUN) begin
            lap_hold_d = ~lap_hold_q;
         end else if (state_q == ST_STOP) begin
            lap_hold_d = 1'b0;
         end
      end
   end
`else
   logic unused_lap;
   assign unused_lap = i_btn_lap;
`endif

   // Moore outputs decoded straight from the state register.
   always_comb begin
      o_run   = (state_q == ST_RUN);
      o_clear = (state_q == ST_CLEAR);
      o_state = state_q;
`ifdef STOPWATCH_LAP_EN
      o_lap_hold = lap_hold_q;
`else
      o_lap_hold = 1'b0;
`endif
   end

endmodule
